// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the two-port ROM access arbiter.
// Response payload layout and the request address validity check live here.
package rom_arb_pkg;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DBG   = 1;

    localparam int RSP_DATA_W = 32;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] data;
        logic                  err;
    } rom_rsp_t;

    // Addresses arrive zero-extended to 64 bits so the word index and ROM size
    // compare without truncation for any address width up to 64.
    function automatic logic rom_addr_err(input logic [63:0] addr, input logic [63:0] rom_size);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[63:2]} >= rom_size);
    endfunction

endpackage

// File: rtl/rom_rsp_slot.sv
// Per-port response register: loads on grant, holds until consumed.
// Latency: 1 cycle from load to valid. Backpressure: contents frozen while rsp_ready=0.
import rom_arb_pkg::*;

module rom_rsp_slot (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  rom_rsp_t load_rsp,
    input  logic     rsp_ready,
    output logic     rsp_valid,
    output rom_rsp_t rsp
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp       <= '0;
        end else if (load) begin
            // A reload on the same edge as a drain keeps valid high with no bubble.
            rsp_valid <= 1'b1;
            rsp       <= load_rsp;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one combinational ROM between fetch (port 0) and debug (port 1) requesters.
// Latency: response valid the cycle after grant. Backpressure: a port with a held,
// unconsumed response is not granted. ROM_ARB_RR_EN selects round-robin over fixed priority.
import rom_arb_pkg::*;

module rom_access_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROM_SIZE   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp0_err,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rsp1_err,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    logic [1:0]            elig;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    rom_rsp_t              load_rsp;
    rom_rsp_t              slot0;
    rom_rsp_t              slot1;

    // rst_n gates eligibility so ready stays low throughout reset.
    assign elig[PORT_FETCH] = rst_n && req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig[PORT_DBG]   = rst_n && req1_valid && (!rsp1_valid || rsp1_ready);

`ifdef ROM_ARB_RR_EN
    logic rr_ptr;   // 0: fetch preferred, 1: debug preferred

    assign gnt[PORT_FETCH] = elig[PORT_FETCH] && (!elig[PORT_DBG] || !rr_ptr);
    assign gnt[PORT_DBG]   = elig[PORT_DBG] && (!elig[PORT_FETCH] || rr_ptr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (gnt[PORT_FETCH]) begin
            rr_ptr <= 1'b1;
        end else if (gnt[PORT_DBG]) begin
            rr_ptr <= 1'b0;
        end
    end
`else
    assign gnt[PORT_FETCH] = elig[PORT_FETCH];
    assign gnt[PORT_DBG]   = elig[PORT_DBG] && !elig[PORT_FETCH];
`endif

    assign req0_ready = gnt[PORT_FETCH];
    assign req1_ready = gnt[PORT_DBG];

    assign sel_addr = gnt[PORT_DBG] ? req1_addr : req0_addr;
    // Idle cycles replay the last granted address so the ROM input does not toggle.
    assign rom_addr = (|gnt) ? sel_addr : last_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_addr <= '0;
        end else if (|gnt) begin
            last_addr <= sel_addr;
        end
    end

    always_comb begin
        load_rsp      = '0;
        load_rsp.err  = rom_addr_err(64'(sel_addr), 64'(ROM_SIZE));
        load_rsp.data = load_rsp.err ? '0 : RSP_DATA_W'(rom_data);
    end

    rom_rsp_slot u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (gnt[PORT_FETCH]),
        .load_rsp  (load_rsp),
        .rsp_ready (rsp0_ready),
        .rsp_valid (rsp0_valid),
        .rsp       (slot0)
    );

    rom_rsp_slot u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (gnt[PORT_DBG]),
        .load_rsp  (load_rsp),
        .rsp_ready (rsp1_ready),
        .rsp_valid (rsp1_valid),
        .rsp       (slot1)
    );

    assign rsp0_data = DATA_WIDTH'(slot0.data);
    assign rsp0_err  = slot0.err;
    assign rsp1_data = DATA_WIDTH'(slot1.data);
    assign rsp1_err  = slot1.err;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter; ROM model returns 0xC0DE0000 | word index.
module tb_rom_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_addr;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic [31:0] rsp0_data;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_addr;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp1_data;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rom_data = 32'hC0DE_0000 | (rom_addr >> 2);

    rom_access_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROM_SIZE(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 32'h8;
        rsp0_ready = 1'b0;
        req1_valid = 1'b0;
        req1_addr  = 32'h0;
        rsp1_ready = 1'b0;
        tick();
        tick();
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        chk("rst_rsp0_err", rsp0_err, 0);
        chk("rst_req0_ready_gated", req0_ready, 0);

        req0_valid = 1'b0;
        rst_n      = 1'b1;
        tick();
        chk("idle_req0_ready", req0_ready, 0);
        chk("idle_req1_ready", req1_ready, 0);
        chk("idle_rsp0_valid", rsp0_valid, 0);

        // Single fetch of word 2
        req0_valid = 1'b1;
        req0_addr  = 32'h8;
        rsp0_ready = 1'b1;
        #1;
        chk("p0_req0_ready", req0_ready, 1);
        chk("p0_req1_ready", req1_ready, 0);
        chk("p0_rom_addr", rom_addr, 32'h8);
        tick();
        chk("p0_rsp_valid", rsp0_valid, 1);
        chk("p0_rsp_data", rsp0_data, 32'hC0DE0002);
        chk("p0_rsp_err", rsp0_err, 0);
        req0_valid = 1'b0;
        #1;
        chk("p0_idle_ready", req0_ready, 0);
        chk("p0_rom_addr_hold", rom_addr, 32'h8);
        tick();
        chk("p0_drained", rsp0_valid, 0);

        // Contention: both ports request with consumers draining every cycle
        req0_valid = 1'b1;
        req0_addr  = 32'h4;
        req1_valid = 1'b1;
        req1_addr  = 32'hC;
        rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ROM_ARB_RR_EN
            // Last grant was port 0, so the pointer starts at port 1.
            chk("rr_req0_ready", req0_ready, (i % 2 == 1) ? 1 : 0);
            chk("rr_req1_ready", req1_ready, (i % 2 == 0) ? 1 : 0);
`else
            chk("fp_req0_ready", req0_ready, 1);
            chk("fp_req1_ready", req1_ready, 0);
            chk("fp_rom_addr", rom_addr, 32'h4);
`endif
            tick();
        end
        chk("cont_rsp0_valid", rsp0_valid, 1);
        chk("cont_rsp0_data", rsp0_data, 32'hC0DE0001);
        chk("cont_rsp1_valid", rsp1_valid, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Port 1 error checks and the last in-range word, back to back
        req1_valid = 1'b1;
        req1_addr  = 32'h6;
        #1;
        chk("p1_req1_ready", req1_ready, 1);
        tick();
        chk("mis_valid", rsp1_valid, 1);
        chk("mis_err", rsp1_err, 1);
        chk("mis_data", rsp1_data, 0);
        req1_addr = 32'hFC;
        #1;
        chk("p1_reload_ready", req1_ready, 1);
        tick();
        chk("top_valid", rsp1_valid, 1);
        chk("top_err", rsp1_err, 0);
        chk("top_data", rsp1_data, 32'hC0DE003F);
        req1_addr = 32'h100;
        tick();
        chk("oor_valid", rsp1_valid, 1);
        chk("oor_err", rsp1_err, 1);
        chk("oor_data", rsp1_data, 0);
        req1_valid = 1'b0;
        tick();
        chk("p1_drained", rsp1_valid, 0);

        // Consumer stall on port 0, then no-bubble reload
        req0_valid = 1'b1;
        req0_addr  = 32'h10;
        rsp0_ready = 1'b0;
        tick();
        chk("hold_first_valid", rsp0_valid, 1);
        chk("hold_first_data", rsp0_data, 32'hC0DE0004);
        req0_addr = 32'h14;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_req0_ready", req0_ready, 0);
            chk("hold_rom_addr", rom_addr, 32'h10);
            tick();
            chk("hold_valid", rsp0_valid, 1);
            chk("hold_data", rsp0_data, 32'hC0DE0004);
        end
        rsp0_ready = 1'b1;
        #1;
        chk("reload_ready", req0_ready, 1);
        tick();
        chk("reload_valid", rsp0_valid, 1);
        chk("reload_data", rsp0_data, 32'hC0DE0005);
        req0_valid = 1'b0;
        tick();
        chk("reload_drained", rsp0_valid, 0);

        // Reset with a response pending
        req0_valid = 1'b1;
        req0_addr  = 32'h20;
        rsp0_ready = 1'b0;
        tick();
        chk("pend_valid", rsp0_valid, 1);
        chk("pend_data", rsp0_data, 32'hC0DE0008);
        req0_valid = 1'b0;
        rst_n      = 1'b0;
        tick();
        chk("midrst_valid", rsp0_valid, 0);
        chk("midrst_data", rsp0_data, 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", rsp0_valid, 0);
        chk("post_rst_valid1", rsp1_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
